cache_line_state_ctrl: RTL and testbench

//  Parametrised successor of the 2-way valid/dirty/last-used bit logic. Holds per-line valid,

---
 rtl/cache_meta_pkg.sv | 26 ++
 rtl/lru_age_update.sv | 58 +++++
 rtl/cache_line_state_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cache_line_state_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_meta_pkg.sv
// Shared types for the cache line metadata block.
//   op_code_e     : operation codes on op_code
//   flush_state_e : flush sequencer states
//   age_mode_e    : age update mode (touch on access/fill, demote on invalidate)
package cache_meta_pkg;

    typedef enum logic [1:0] {
        OP_READ_HIT   = 2'b00,
        OP_WRITE_HIT  = 2'b01,
        OP_FILL       = 2'b10,
        OP_INVALIDATE = 2'b11
    } op_code_e;

    typedef enum logic [1:0] {
        FL_IDLE    = 2'b00,
        FL_SCAN    = 2'b01,
        FL_WB_WAIT = 2'b10,
        FL_DONE    = 2'b11
    } flush_state_e;

    typedef enum logic {
        AGE_TOUCH      = 1'b0,
        AGE_INVALIDATE = 1'b1
    } age_mode_e;

endpackage

// File: rtl/lru_age_update.sv
// Combinational true-LRU age update and victim selection for one set.
//   ages     : current age per way (0 = most recently used)
//   valid    : valid bit per way (victim selection only)
//   way      : way being touched / invalidated
//   mode     : AGE_TOUCH or AGE_INVALIDATE
//   new_ages : ages after applying mode to way
//   victim   : lowest-index invalid way, else the way with age WAYS-1
module lru_age_update
    import cache_meta_pkg::*;
#(
    parameter  int WAYS  = 2,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][WAY_W-1:0] ages,
    input  logic [WAYS-1:0]            valid,
    input  logic [WAY_W-1:0]           way,
    input  age_mode_e                  mode,
    output logic [WAYS-1:0][WAY_W-1:0] new_ages,
    output logic [WAY_W-1:0]           victim
);

    logic [WAY_W-1:0] old_age;
    logic             found;

    assign old_age = ages[way];

    always_comb begin
        new_ages = ages;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (WAY_W'(i) == way) begin
                new_ages[i] = (mode == AGE_TOUCH) ? '0 : WAY_W'(WAYS - 1);
            end else if (mode == AGE_TOUCH && ages[i] < old_age) begin
                new_ages[i] = ages[i] + WAY_W'(1);
            end else if (mode == AGE_INVALIDATE && ages[i] > old_age) begin
                new_ages[i] = ages[i] - WAY_W'(1);
            end
        end
    end

    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!valid[i] && !found) begin
                victim = WAY_W'(i);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
                if (ages[i] == WAY_W'(WAYS - 1)) begin
                    victim = WAY_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/cache_line_state_ctrl.sv
// Per-line valid/dirty/true-LRU state for a WAYS-way, NUM_SETS-set cache.
//   op_*        : metadata op request (READ_HIT, WRITE_HIT, FILL, INVALIDATE)
//   q_set/q_*   : registered query of valid, dirty and victim for one set
//   flush_*     : flush request/status; flush writes back every dirty line
//   wb_*        : write-back valid/ready handshake towards the data path
module cache_line_state_ctrl
    import cache_meta_pkg::*;
#(
    parameter  int WAYS     = 2,
    parameter  int NUM_SETS = 16,
    localparam int WAY_W    = $clog2(WAYS),
    localparam int SET_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [SET_W-1:0] op_set,
    input  logic [WAY_W-1:0] op_way,
    input  logic             op_dirty,
    input  logic [SET_W-1:0] q_set,
    output logic [WAYS-1:0]  q_valid,
    output logic [WAYS-1:0]  q_dirty,
    output logic [WAY_W-1:0] q_victim,
    input  logic             flush_start,
    output logic             flush_busy,
    output logic             flush_done,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [SET_W-1:0] wb_set,
    output logic [WAY_W-1:0] wb_way
);

    localparam int IDX_W = SET_W + WAY_W;

    logic [WAYS-1:0]            valid_q  [NUM_SETS];
    logic [WAYS-1:0]            dirty_q  [NUM_SETS];
    logic [WAYS-1:0][WAY_W-1:0] age_q    [NUM_SETS];
    logic [WAYS-1:0][WAY_W-1:0] age_next [NUM_SETS];
    logic [WAY_W-1:0]           victim   [NUM_SETS];

    flush_state_e     state;
    logic [IDX_W-1:0] scan_idx;
    logic [SET_W-1:0] scan_set;
    logic [WAY_W-1:0] scan_way;
    logic             scan_last;
    logic             line_wb;
    logic             op_fire;
    age_mode_e        op_mode;

    // One updater per set: the op set's new ages and the query set's victim
    // both come from this bank without a second mux-fed instance.
    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        lru_age_update #(.WAYS(WAYS)) u_lru (
            .ages     (age_q[s]),
            .valid    (valid_q[s]),
            .way      (op_way),
            .mode     (op_mode),
            .new_ages (age_next[s]),
            .victim   (victim[s])
        );
    end

    assign op_mode    = (op_code == OP_INVALIDATE) ? AGE_INVALIDATE : AGE_TOUCH;
    assign op_ready   = (state == FL_IDLE);
    assign op_fire    = op_valid && op_ready;
    assign flush_busy = (state != FL_IDLE);
    assign flush_done = (state == FL_DONE);
    assign wb_valid   = (state == FL_WB_WAIT);

    // Scan index is set-major: upper bits select the set, lower bits the way.
    assign scan_set  = scan_idx[IDX_W-1 -: SET_W];
    assign scan_way  = scan_idx[WAY_W-1:0];
    assign scan_last = &scan_idx;
    assign line_wb   = valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WAY_W'(w);
                end
            end
            state    <= FL_IDLE;
            scan_idx <= '0;
            wb_set   <= '0;
            wb_way   <= '0;
            q_valid  <= '0;
            q_dirty  <= '0;
            q_victim <= '0;
        end else begin
            q_valid  <= valid_q[q_set];
            q_dirty  <= dirty_q[q_set];
            q_victim <= victim[q_set];

            if (op_fire) begin
                case (op_code_e'(op_code))
                    OP_READ_HIT: begin
                        if (valid_q[op_set][op_way]) begin
                            age_q[op_set] <= age_next[op_set];
                        end
                    end
                    OP_WRITE_HIT: begin
                        if (valid_q[op_set][op_way]) begin
                            dirty_q[op_set][op_way] <= 1'b1;
                            age_q[op_set]           <= age_next[op_set];
                        end
                    end
                    OP_FILL: begin
                        valid_q[op_set][op_way] <= 1'b1;
                        dirty_q[op_set][op_way] <= op_dirty;
                        age_q[op_set]           <= age_next[op_set];
                    end
                    OP_INVALIDATE: begin
                        valid_q[op_set][op_way] <= 1'b0;
                        dirty_q[op_set][op_way] <= 1'b0;
                        age_q[op_set]           <= age_next[op_set];
                    end
                    default: ;
                endcase
            end

            case (state)
                FL_IDLE: begin
                    if (flush_start && !op_valid) begin
                        state    <= FL_SCAN;
                        scan_idx <= '0;
                    end
                end
                FL_SCAN: begin
                    if (line_wb) begin
                        state  <= FL_WB_WAIT;
                        wb_set <= scan_set;
                        wb_way <= scan_way;
                    end else if (scan_last) begin
                        state <= FL_DONE;
                    end else begin
                        scan_idx <= scan_idx + IDX_W'(1);
                    end
                end
                FL_WB_WAIT: begin
                    if (wb_ready) begin
                        dirty_q[wb_set][wb_way] <= 1'b0;
                        if (scan_last) begin
                            state <= FL_DONE;
                        end else begin
                            state    <= FL_SCAN;
                            scan_idx <= scan_idx + IDX_W'(1);
                        end
                    end
                end
                FL_DONE: state <= FL_IDLE;
                default: state <= FL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_state_ctrl.sv
// Self-checking bench for cache_line_state_ctrl (WAYS=4, NUM_SETS=16).
// The reference keeps per-set recency as an MRU-first list of ways.
module tb_cache_line_state_ctrl;

    localparam int WAYS     = 4;
    localparam int NUM_SETS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op_code;
    logic [3:0] op_set;
    logic [1:0] op_way;
    logic       op_dirty;
    logic [3:0] q_set;
    logic [3:0] q_valid;
    logic [3:0] q_dirty;
    logic [1:0] q_victim;
    logic       flush_start;
    logic       flush_busy;
    logic       flush_done;
    logic       wb_valid;
    logic       wb_ready;
    logic [3:0] wb_set;
    logic [1:0] wb_way;

    always #5 clk = ~clk;

    cache_line_state_ctrl #(.WAYS(WAYS), .NUM_SETS(NUM_SETS)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_set(op_set), .op_way(op_way), .op_dirty(op_dirty),
        .q_set(q_set), .q_valid(q_valid), .q_dirty(q_dirty), .q_victim(q_victim),
        .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_set(wb_set), .wb_way(wb_way)
    );

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [3:0] mv [NUM_SETS];
    logic [3:0] md [NUM_SETS];
    int         lru [NUM_SETS][$];   // MRU first, LRU last

    typedef struct {
        int         code;
        int         set;
        int         way;
        bit         dirty;
        logic [3:0] ev;
        logic [3:0] ed;
        int         evict;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            mv[s] = '0;
            md[s] = '0;
            lru[s].delete();
            for (int w = 0; w < WAYS; w++) lru[s].push_back(w);
        end
    endtask

    task automatic lru_remove(input int s, input int w);
        for (int i = 0; i < lru[s].size(); i++) begin
            if (lru[s][i] == w) begin
                lru[s].delete(i);
                break;
            end
        end
    endtask

    task automatic model_op(input int code, input int s, input int w, input bit d);
        case (code)
            0: if (mv[s][w]) begin lru_remove(s, w); lru[s].push_front(w); end
            1: if (mv[s][w]) begin md[s][w] = 1'b1; lru_remove(s, w); lru[s].push_front(w); end
            2: begin mv[s][w] = 1'b1; md[s][w] = d; lru_remove(s, w); lru[s].push_front(w); end
            default: begin mv[s][w] = 1'b0; md[s][w] = 1'b0; lru_remove(s, w); lru[s].push_back(w); end
        endcase
    endtask

    function automatic int model_victim(input int s);
        for (int w = 0; w < WAYS; w++) if (!mv[s][w]) return w;
        return lru[s][lru[s].size() - 1];
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic do_op(input int code, input int s, input int w, input bit d);
        op_valid = 1'b1;
        op_code  = 2'(code);
        op_set   = 4'(s);
        op_way   = 2'(w);
        op_dirty = d;
        step();
        op_valid = 1'b0;
        model_op(code, s, w, d);
    endtask

    task automatic check_set(input int s);
        q_set = 4'(s);
        step();
        check("q_valid", 32'(q_valid), 32'(mv[s]));
        check("q_dirty", 32'(q_dirty), 32'(md[s]));
        check("q_victim", 32'(q_victim), 32'(model_victim(s)));
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        while (!wb_valid && n < 200) begin
            step();
            n++;
        end
        check("wb_wait_timeout", 32'(wb_valid), 32'd1);
    endtask

    task automatic flush_service();
        int exp_ids[$];
        int n;
        bit done;
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (mv[s][w] && md[s][w]) exp_ids.push_back(s * WAYS + w);
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            wb_ready = 1'($urandom_range(0, 1));
            if (wb_valid && wb_ready) begin
                check("wb_line", 32'(int'(wb_set) * WAYS + int'(wb_way)),
                      32'((exp_ids.size() > 0) ? exp_ids[0] : 255));
                if (exp_ids.size() > 0) exp_ids.pop_front();
                md[wb_set][wb_way] = 1'b0;
            end
            step();
            n++;
            if (flush_done) done = 1'b1;
        end
        wb_ready = 1'b0;
        check("flush_done_seen", 32'(done), 32'd1);
        check("wb_remaining", 32'(exp_ids.size()), 32'd0);
        step();
        check("flush_done_pulse", 32'(flush_done), 32'd0);
        check("flush_idle", 32'(flush_busy), 32'd0);
    endtask

    task automatic run_flush();
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        flush_service();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; op_valid = 1'b0; op_code = '0; op_set = '0; op_way = '0;
        op_dirty = 1'b0; q_set = '0; flush_start = 1'b0; wb_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();

        // Reset state
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_busy", 32'(flush_busy), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_done", 32'(flush_done), 32'd0);
        check("rst_wb_set", 32'(wb_set), 32'd0);
        q_set = 4'd3;
        step();
        check("rst_q_valid", 32'(q_valid), 32'h0);
        check("rst_q_dirty", 32'(q_dirty), 32'h0);
        check("rst_q_victim", 32'(q_victim), 32'd0);

        // Directed op sequence on set 3
        tbl[0] = '{2, 3, 0, 1'b0, 4'b0001, 4'b0000, 1};
        tbl[1] = '{2, 3, 1, 1'b0, 4'b0011, 4'b0000, 2};
        tbl[2] = '{2, 3, 2, 1'b0, 4'b0111, 4'b0000, 3};
        tbl[3] = '{2, 3, 3, 1'b0, 4'b1111, 4'b0000, 0};
        tbl[4] = '{0, 3, 0, 1'b0, 4'b1111, 4'b0000, 1};
        tbl[5] = '{1, 3, 1, 1'b0, 4'b1111, 4'b0010, 2};
        tbl[6] = '{3, 3, 2, 1'b0, 4'b1011, 4'b0010, 2};
        tbl[7] = '{2, 3, 2, 1'b0, 4'b1111, 4'b0010, 3};
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].code, tbl[i].set, tbl[i].way, tbl[i].dirty);
            q_set = 4'(tbl[i].set);
            step();
            check("tbl_q_valid", 32'(q_valid), 32'(tbl[i].ev));
            check("tbl_q_dirty", 32'(q_dirty), 32'(tbl[i].ed));
            check("tbl_q_victim", 32'(q_victim), 32'(tbl[i].evict));
        end

        // Flush with a stalled first write-back
        reset_dut();
        do_op(2, 1, 1, 1'b1);
        do_op(2, 5, 0, 1'b1);
        do_op(2, 2, 3, 1'b0);
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        check("flush_busy", 32'(flush_busy), 32'd1);
        check("op_ready_busy", 32'(op_ready), 32'd0);
        wait_wb(n);
        check("wb1_latency", 32'(n), 32'd6);
        check("wb1_set", 32'(wb_set), 32'd1);
        check("wb1_way", 32'(wb_way), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("wb1_hold_valid", 32'(wb_valid), 32'd1);
            check("wb1_hold_line", 32'({wb_set, wb_way}), 32'({4'd1, 2'd1}));
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        md[1][1] = 1'b0;
        wait_wb(n);
        check("wb2_latency", 32'(n), 32'd15);
        check("wb2_line", 32'({wb_set, wb_way}), 32'({4'd5, 2'd0}));
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        md[5][0] = 1'b0;
        n = 0;
        while (!flush_done && n < 200) begin
            step();
            n++;
        end
        check("done_latency", 32'(n), 32'd43);
        step();
        check("done_one_pulse", 32'(flush_done), 32'd0);
        check("done_idle", 32'(flush_busy), 32'd0);
        for (int s = 0; s < NUM_SETS; s++) check_set(s);

        // Op and flush_start together: op wins, flush starts a cycle later
        op_valid = 1'b1; op_code = 2'd1; op_set = 4'd2; op_way = 2'd3; flush_start = 1'b1;
        check("collide_ready", 32'(op_ready), 32'd1);
        step();
        op_valid = 1'b0;
        model_op(1, 2, 3, 1'b0);
        check("collide_not_busy", 32'(flush_busy), 32'd0);
        step();
        flush_start = 1'b0;
        check("collide_busy", 32'(flush_busy), 32'd1);
        check("collide_ready_low", 32'(op_ready), 32'd0);
        flush_service();
        check_set(2);

        // Reset in the middle of a write-back wait
        do_op(2, 7, 2, 1'b1);
        flush_start = 1'b1;
        step();
        flush_start = 1'b0;
        wait_wb(n);
        check("abort_wb_line", 32'({wb_set, wb_way}), 32'({4'd7, 2'd2}));
        reset_dut();
        check("abort_wb_valid", 32'(wb_valid), 32'd0);
        check("abort_busy", 32'(flush_busy), 32'd0);
        check("abort_ready", 32'(op_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", 32'(flush_done), 32'd0);
            step();
        end
        check_set(7);
        check_set(3);

        // Random ops against the reference model, with periodic flushes
        for (int i = 0; i < 400; i++) begin
            int qs;
            logic [3:0] ev, ed;
            int evk;
            if (i % 80 == 79) begin
                run_flush();
            end else begin
                op_valid = 1'($urandom_range(0, 1));
                op_code  = 2'($urandom_range(0, 3));
                op_set   = 4'($urandom_range(0, NUM_SETS - 1));
                op_way   = 2'($urandom_range(0, WAYS - 1));
                op_dirty = 1'($urandom_range(0, 1));
                qs       = int'($urandom_range(0, NUM_SETS - 1));
                q_set    = 4'(qs);
                ev  = mv[qs];
                ed  = md[qs];
                evk = model_victim(qs);
                check("rnd_op_ready", 32'(op_ready), 32'd1);
                step();
                if (op_valid) model_op(int'(op_code), int'(op_set), int'(op_way), op_dirty);
                op_valid = 1'b0;
                check("rnd_q_valid", 32'(q_valid), 32'(ev));
                check("rnd_q_dirty", 32'(q_dirty), 32'(ed));
                check("rnd_q_victim", 32'(q_victim), 32'(evk));
            end
        end
        for (int s = 0; s < NUM_SETS; s++) check_set(s);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
